resp_serializer: RTL and testbench

- Downstream stage of the command execution datapath.
- Consumes response packets that cmd_dispatcher emits on its response write strobe, buffers them in a small internal FIFO, and serializes each packet into a fixed 5-byte frame.
- Frames are handed byte by byte to uart_tx over a valid/ready handshake, closing the UART request/response loop.

---
 rtl/resp_serializer.sv | 152 +++++++++++++++
 tb/tb_resp_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/resp_serializer.sv
// Response serializer: buffers cmd_dispatcher response packets in a small FIFO and
// streams each one to uart_tx as a 5-byte frame {SOF, opcode, addr, data, CHK}.

package cmd_pkg;
   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] addr;
      logic [7:0] data;
   } cmd_packet_t;
endpackage

module resp_serializer
   import cmd_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        resp_wr_en,
   input  cmd_packet_t resp_wr_data,
   output logic        resp_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   cmd_packet_t       mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d;
   logic              overflow_q, overflow_d;
   logic [0:0]        state_q, state_d;
   logic [2:0]        byte_idx_q, byte_idx_d;
   cmd_packet_t       pkt_q, pkt_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;

   logic              xfer;
   logic              last_xfer;
   logic              pop;
   logic              wr_acc;
   cmd_packet_t       head;

   function automatic logic [7:0] frame_byte(input cmd_packet_t p, input logic [2:0] idx);
      case (idx)
         3'd0:    frame_byte = SOF_BYTE;
         3'd1:    frame_byte = p.opcode;
         3'd2:    frame_byte = p.addr;
         3'd3:    frame_byte = p.data;
         default: frame_byte = p.opcode ^ p.addr ^ p.data;
      endcase
   endfunction

   assign head      = mem_q[rd_ptr_q];
   assign xfer      = tx_valid_q & tx_ready;
   assign last_xfer = xfer & (byte_idx_q == 3'd4);
   // A pop happens on entry from IDLE or chained onto the final byte of a frame.
   assign pop       = (count_q != '0) & ((state_q == IDLE) | last_xfer);
   // A same-edge pop frees a slot, so a full FIFO still accepts the write.
   assign wr_acc    = resp_wr_en & (~full_q | pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q | (resp_wr_en & full_q & ~pop);
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
      count_d    = count_q + CW'(wr_acc) - CW'(pop);
      full_d     = (count_d == CW'(DEPTH));
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      pkt_d      = pkt_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d    = SEND;
               byte_idx_d = 3'd0;
               pkt_d      = head;
               tx_valid_d = 1'b1;
               tx_data_d  = SOF_BYTE;
            end
         end
         default: begin
            if (xfer) begin
               if (byte_idx_q != 3'd4) begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  tx_data_d  = frame_byte(pkt_q, byte_idx_q + 3'd1);
               end else if (pop) begin
                  byte_idx_d = 3'd0;
                  pkt_d      = head;
                  tx_data_d  = SOF_BYTE;
               end else begin
                  state_d    = IDLE;
                  tx_valid_d = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= resp_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         byte_idx_q <= '0;
         pkt_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         pkt_q      <= pkt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign resp_full = full_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign overflow  = overflow_q;
   assign busy      = (state_q == SEND) | (count_q != '0);

endmodule

// File: tb/tb_resp_serializer.sv
// Directed bench for resp_serializer: frame content, latency, backpressure,
// overflow, chained frames, full write+pop and mid-frame reset.

module tb_resp_serializer;
   import cmd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        resp_wr_en;
   cmd_packet_t resp_wr_data;
   logic        resp_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        overflow;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [7:0]  rxq [$];
   logic [7:0]  expq [$];
   int unsigned gaps;
   int unsigned holdv;

   resp_serializer #(.DEPTH(4), .SOF_BYTE(8'hA5)) dut (
      .clk          (clk),
      .rst          (rst),
      .resp_wr_en   (resp_wr_en),
      .resp_wr_data (resp_wr_data),
      .resp_full    (resp_full),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input cmd_packet_t p);
      resp_wr_en   = 1'b1;
      resp_wr_data = p;
      @(negedge clk);
      resp_wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_frame(input cmd_packet_t p);
      expq.push_back(8'hA5);
      expq.push_back(p.opcode);
      expq.push_back(p.addr);
      expq.push_back(p.data);
      expq.push_back(p.opcode ^ p.addr ^ p.data);
   endtask

   // Collect n transferred bytes; mode 0: ready always 1, mode 1: ready 1,0,0,1,0,0...
   task automatic run_rx(input string tag, input int n, input int mode, input int maxc);
      logic       started, prev_wait, r;
      logic [7:0] prev_data;
      rxq.delete();
      gaps = 0; holdv = 0; started = 0; prev_wait = 0; prev_data = '0;
      for (int i = 0; i < maxc && rxq.size() < n; i++) begin
         if (prev_wait && !(tx_valid && tx_data == prev_data)) holdv++;
         if (started && !tx_valid) gaps++;
         r = (mode == 0) ? 1'b1 : ((i % 3) == 0);
         tx_ready = r;
         if (tx_valid) begin
            started = 1'b1;
            if (r) rxq.push_back(tx_data);
         end
         prev_wait = tx_valid && !r;
         prev_data = tx_data;
         @(negedge clk);
      end
      chk({tag, "_count"}, rxq.size(), n);
      chk({tag, "_hold"}, holdv, 0);
      for (int k = 0; k < n && k < rxq.size() && k < expq.size(); k++)
         chk($sformatf("%s_b%0d", tag, k), rxq[k], expq[k]);
      expq.delete();
   endtask

   cmd_packet_t pk [6];

   initial begin
      rst = 1'b1; resp_wr_en = 1'b0; resp_wr_data = '0; tx_ready = 1'b1;
      pk[0] = '{8'h02, 8'h10, 8'h3C};
      pk[1] = '{8'h11, 8'h22, 8'h44};
      pk[2] = '{8'hFF, 8'h00, 8'h0F};
      pk[3] = '{8'h81, 8'h7E, 8'h55};
      pk[4] = '{8'h00, 8'h00, 8'h00};
      pk[5] = '{8'hC3, 8'h96, 8'h01};

      // Reset state
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 8'h00);
      chk("rst_full", resp_full, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);

      // Single packet, ready tied high; valid appears two edges after the strobe
      wr(pk[0]);
      chk("t1_valid_e0", tx_valid, 0);
      chk("t1_busy_e0", busy, 1);
      @(negedge clk);
      chk("t1_valid_e1", tx_valid, 1);
      expq = '{8'hA5, 8'h02, 8'h10, 8'h3C, 8'h2E};
      run_rx("t1", 5, 0, 20);
      chk("t1_gaps", gaps, 0);
      chk("t1_idle_valid", tx_valid, 0);
      chk("t1_idle_busy", busy, 0);

      // Backpressure
      wr(pk[0]);
      expq = '{8'hA5, 8'h02, 8'h10, 8'h3C, 8'h2E};
      run_rx("t2", 5, 1, 40);
      @(negedge clk);
      chk("t2_idle_valid", tx_valid, 0);
      chk("t2_idle_busy", busy, 0);

      // Burst of 6 with ready low: one in frame, four stored, sixth dropped
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) wr(pk[i]);
      chk("t3_full", resp_full, 1);
      chk("t3_ovf", overflow, 1);
      chk("t3_first", tx_data, 8'hA5);
      for (int i = 0; i < 5; i++) push_frame(pk[i]);
      run_rx("t3", 25, 0, 60);
      chk("t3_gaps", gaps, 0);
      @(negedge clk);
      chk("t3_done_valid", tx_valid, 0);
      chk("t3_done_busy", busy, 0);
      chk("t3_ovf_sticky", overflow, 1);

      do_reset();
      chk("t3_ovf_cleared", overflow, 0);

      // Back-to-back: 3 queued, 15 bytes without bubbles
      tx_ready = 1'b0;
      for (int i = 1; i < 4; i++) wr(pk[i]);
      for (int i = 1; i < 4; i++) push_frame(pk[i]);
      run_rx("t4", 15, 0, 40);
      chk("t4_gaps", gaps, 0);
      @(negedge clk);
      chk("t4_done_valid", tx_valid, 0);

      // Full FIFO, write on the edge of the last byte transfer
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(pk[i]);
      chk("t5_full", resp_full, 1);
      chk("t5_ovf0", overflow, 0);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("t5_chk_byte", tx_data, 8'h2E);
      wr(pk[5]);
      chk("t5_ovf_after", overflow, 0);
      chk("t5_full_after", resp_full, 1);
      chk("t5_next_sof", tx_data, 8'hA5);
      for (int i = 1; i < 6; i++) push_frame(pk[i]);
      run_rx("t5", 25, 0, 60);
      @(negedge clk);
      chk("t5_done_busy", busy, 0);

      // Reset mid-frame with two packets queued
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) wr(pk[i]);
      tx_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("t6_mid_byte", tx_data, 8'h10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_valid", tx_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_full", resp_full, 0);
      chk("t6_ovf", overflow, 0);
      begin
         int unsigned vcnt;
         vcnt = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid) vcnt++;
         end
         chk("t6_no_residual", vcnt, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
